// File: rtl/rambus_bridge_pkg.sv
// Shared definitions for the APB-to-RamBus bridge: FSM states, bus widths
// common with the DM main register block, and small datapath helpers.
package rambus_bridge_pkg;

    localparam int          RB_ADDR_W          = 14;
    localparam int          RB_DATA_W          = 32;
    localparam logic [31:0] RB_TIMEOUT_PATTERN = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc16 = value;
        end else begin
            sat_inc16 = value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/apb_rambus_bridge.sv
// APB3 slave to RamBus master bridge. One RamBus cycle per APB transfer,
// with a bounded wait for RamBusAck so a hung register block cannot stall
// the processor. Every output comes straight from a flop.
module apb_rambus_bridge
    import rambus_bridge_pkg::*;
#(
    parameter int                ADDR_W          = RB_ADDR_W,
    parameter int                DATA_W          = RB_DATA_W,
    parameter int                TIMEOUT_CYCLES  = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_PATTERN = RB_TIMEOUT_PATTERN
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [ADDR_W-1:0] RamBusAddress,
    output logic [DATA_W-1:0] RamBusDataIn,
    output logic              RamBusnCs,
    output logic              RamBusWrnRd,
    output logic              RamBusLatch,
    input  logic [DATA_W-1:0] RamBusDataOut,
    input  logic              RamBusAck,
    output logic [15:0]       TimeoutCount
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t              state_r, state_s;
    logic [DATA_W-1:0]   prdata_r, prdata_s;
    logic                pready_r, pready_s;
    logic                pslverr_r, pslverr_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   din_r, din_s;
    logic                ncs_r, ncs_s;
    logic                wrnrd_r, wrnrd_s;
    logic                latch_r, latch_s;
    logic [15:0]         tcount_r, tcount_s;
    logic [15:0]         timer_r, timer_s;
    logic                sel_s;

    // Setup and access phases are treated alike: only PSEL starts or keeps a
    // transfer alive, PENABLE folds in without changing the select value.
    assign sel_s = PSEL | (PSEL & PENABLE);

    // Next-state and next-output decode for the transfer FSM.
    always_comb begin
        state_s   = state_r;
        prdata_s  = prdata_r;
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        addr_s    = addr_r;
        din_s     = din_r;
        ncs_s     = ncs_r;
        wrnrd_s   = wrnrd_r;
        latch_s   = 1'b0;
        tcount_s  = tcount_r;
        timer_s   = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_s) begin
                    addr_s  = PADDR;
                    din_s   = PWDATA;
                    wrnrd_s = PWRITE;
                    ncs_s   = 1'b0;
                    latch_s = 1'b1;
                    timer_s = 16'd1;
                    state_s = ST_ISSUE;
                end else begin
                    ncs_s   = 1'b1;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (!sel_s) begin
                    // Master abandoned the transfer: release the bus quietly.
                    ncs_s   = 1'b1;
                    timer_s = 16'd0;
                    state_s = ST_IDLE;
                end else if (RamBusAck) begin
                    prdata_s = wrnrd_r ? {DATA_W{1'b0}} : RamBusDataOut;
                    pready_s = 1'b1;
                    ncs_s    = 1'b1;
                    timer_s  = 16'd0;
                    state_s  = ST_RESP;
                end else if ((state_r == ST_WAIT) && (timer_r == TIMEOUT_LIM)) begin
                    prdata_s  = wrnrd_r ? {DATA_W{1'b0}} : TIMEOUT_PATTERN;
                    pready_s  = 1'b1;
                    pslverr_s = 1'b1;
                    ncs_s     = 1'b1;
                    tcount_s  = sat_inc16(tcount_r);
                    timer_s   = 16'd0;
                    state_s   = ST_RESP;
                end else begin
                    // The issue cycle holds the timer; it counts only while waiting.
                    if (state_r == ST_WAIT) begin
                        timer_s = timer_r + 16'd1;
                    end else begin
                        timer_s = timer_r;
                    end
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                ncs_s   = 1'b1;
                timer_s = 16'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_r   <= ST_IDLE;
            prdata_r  <= {DATA_W{1'b0}};
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            din_r     <= {DATA_W{1'b0}};
            ncs_r     <= 1'b1;
            wrnrd_r   <= 1'b0;
            latch_r   <= 1'b0;
            tcount_r  <= 16'd0;
            timer_r   <= 16'd0;
        end else begin
            state_r   <= state_s;
            prdata_r  <= prdata_s;
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
            addr_r    <= addr_s;
            din_r     <= din_s;
            ncs_r     <= ncs_s;
            wrnrd_r   <= wrnrd_s;
            latch_r   <= latch_s;
            tcount_r  <= tcount_s;
            timer_r   <= timer_s;
        end
    end

    assign PRDATA        = prdata_r;
    assign PREADY        = pready_r;
    assign PSLVERR       = pslverr_r;
    assign RamBusAddress = addr_r;
    assign RamBusDataIn  = din_r;
    assign RamBusnCs     = ncs_r;
    assign RamBusWrnRd   = wrnrd_r;
    assign RamBusLatch   = latch_r;
    assign TimeoutCount  = tcount_r;

endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Directed testbench for apb_rambus_bridge with a short timeout (8 cycles).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_apb_rambus_bridge;

    logic        clk = 1'b0;
    logic        nRst;
    logic        PSEL, PENABLE, PWRITE;
    logic [13:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [13:0] RamBusAddress;
    logic [31:0] RamBusDataIn, RamBusDataOut;
    logic        RamBusnCs, RamBusWrnRd, RamBusLatch, RamBusAck;
    logic [15:0] TimeoutCount;

    int total = 0;
    int bad   = 0;

    apb_rambus_bridge #(.ADDR_W(14), .DATA_W(32), .TIMEOUT_CYCLES(8),
                        .TIMEOUT_PATTERN(32'hDEADBEEF)) dut (
        .clk(clk), .nRst(nRst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .RamBusAddress(RamBusAddress), .RamBusDataIn(RamBusDataIn),
        .RamBusnCs(RamBusnCs), .RamBusWrnRd(RamBusWrnRd), .RamBusLatch(RamBusLatch),
        .RamBusDataOut(RamBusDataOut), .RamBusAck(RamBusAck), .TimeoutCount(TimeoutCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer starting in the current (idle) cycle T0, observed over a
    // fixed 20-cycle window. ack_k: ack driven in cycle T1+ack_k (-1 = never).
    // drop_k: PSEL released in cycle T<drop_k> (0 = never).
    task automatic run_xfer(input logic wr, input logic [13:0] a, input logic [31:0] d,
                            input int ack_k, input logic [31:0] rdata, input int drop_k,
                            output int ready_cyc, output int ready_cnt, output int ncs_low,
                            output int latch_hi, output logic err, output logic [31:0] prd,
                            output logic wrnrd_seen, output logic [13:0] addr_seen,
                            output logic [31:0] din_seen);
        ready_cyc = -1; ready_cnt = 0; ncs_low = 0; latch_hi = 0;
        err = 1'b0; prd = 32'h0; wrnrd_seen = 1'b0; addr_seen = 14'h0; din_seen = 32'h0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        RamBusAck = 1'b0; RamBusDataOut = rdata;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (PSEL) PENABLE = 1'b1;
            if (j == 1) begin
                wrnrd_seen = RamBusWrnRd; addr_seen = RamBusAddress; din_seen = RamBusDataIn;
            end
            if (RamBusnCs == 1'b0) ncs_low++;
            if (RamBusLatch == 1'b1) latch_hi++;
            if (PREADY === 1'b1) begin
                ready_cnt++;
                if (ready_cyc < 0) begin
                    ready_cyc = j; err = PSLVERR; prd = PRDATA;
                    PSEL = 1'b0; PENABLE = 1'b0;
                end
            end
            RamBusAck = (ack_k >= 0) && (j == ack_k + 1);
            if (j == drop_k) begin PSEL = 1'b0; PENABLE = 1'b0; end
        end
        RamBusAck = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        nRst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 14'h0;
        PWDATA = 32'h0; RamBusDataOut = 32'h0; RamBusAck = 1'b0;
        tick(); tick();
        total++; if ({PRDATA, PREADY, PSLVERR} !== 34'h0) begin bad++;
            $display("FAIL reset_apb got %h/%b/%b want 0/0/0", PRDATA, PREADY, PSLVERR); end
        total++; if ({RamBusnCs, RamBusLatch, RamBusWrnRd} !== 3'b100) begin bad++;
            $display("FAIL reset_ctl got ncs/latch/wr=%b%b%b want 100", RamBusnCs, RamBusLatch, RamBusWrnRd); end
        total++; if ({RamBusAddress, RamBusDataIn, TimeoutCount} !== 62'h0) begin bad++;
            $display("FAIL reset_data got addr=%h din=%h tc=%0d want 0", RamBusAddress, RamBusDataIn, TimeoutCount); end
        nRst = 1'b1;
        tick();
        total++; if ({RamBusnCs, PREADY} !== 2'b10) begin bad++;
            $display("FAIL reset_release got ncs=%b pready=%b want 1/0", RamBusnCs, PREADY); end
    endtask

    task automatic test_write();
        int rc, rn, nl, lh; logic e, w; logic [31:0] p, di; logic [13:0] ad;
        run_xfer(1'b1, 14'h0123, 32'hCAFEF00D, 3, 32'h55555555, 0, rc, rn, nl, lh, e, p, w, ad, di);
        total++; if (rc !== 5) begin bad++; $display("FAIL wr_ready_cycle got %0d want 5", rc); end
        total++; if (nl !== 4) begin bad++; $display("FAIL wr_ncs_low got %0d want 4", nl); end
        total++; if (lh !== 1) begin bad++; $display("FAIL wr_latch got %0d want 1", lh); end
        total++; if (rn !== 1) begin bad++; $display("FAIL wr_ready_count got %0d want 1", rn); end
        total++; if ({e, p} !== 33'h0) begin bad++; $display("FAIL wr_resp got err=%b prdata=%h want 0/0", e, p); end
        total++; if ({w, ad, di} !== {1'b1, 14'h0123, 32'hCAFEF00D}) begin bad++;
            $display("FAIL wr_bus got wr=%b addr=%h din=%h want 1/0123/cafef00d", w, ad, di); end
    endtask

    task automatic test_read_issue_ack();
        int rc, rn, nl, lh; logic e, w; logic [31:0] p, di; logic [13:0] ad;
        run_xfer(1'b0, 14'h0040, 32'h0, 0, 32'h12345678, 0, rc, rn, nl, lh, e, p, w, ad, di);
        total++; if (rc !== 2) begin bad++; $display("FAIL rd_ready_cycle got %0d want 2", rc); end
        total++; if (p !== 32'h12345678) begin bad++; $display("FAIL rd_prdata got %h want 12345678", p); end
        total++; if ({e, w, nl, ad} !== {1'b0, 1'b0, 32'd1, 14'h0040}) begin bad++;
            $display("FAIL rd_bus got err=%b wr=%b ncs_low=%0d addr=%h want 0/0/1/0040", e, w, nl, ad); end
    endtask

    task automatic test_timeout(input logic [15:0] exp_count);
        int rc, rn, nl, lh; logic e, w; logic [31:0] p, di; logic [13:0] ad;
        run_xfer(1'b0, 14'h0200, 32'h0, -1, 32'h0, 0, rc, rn, nl, lh, e, p, w, ad, di);
        total++; if (rc !== 10) begin bad++; $display("FAIL to_ready_cycle got %0d want 10", rc); end
        total++; if ({e, p} !== {1'b1, 32'hDEADBEEF}) begin bad++;
            $display("FAIL to_resp got err=%b prdata=%h want 1/deadbeef", e, p); end
        total++; if (TimeoutCount !== exp_count) begin bad++;
            $display("FAIL to_count got %0d want %0d", TimeoutCount, exp_count); end
        total++; if ({nl, rn, RamBusnCs} !== {32'd9, 32'd1, 1'b1}) begin bad++;
            $display("FAIL to_bus got ncs_low=%0d readies=%0d ncs_after=%b want 9/1/1", nl, rn, RamBusnCs); end
    endtask

    task automatic test_ack_timeout_tie();
        int rc, rn, nl, lh; logic e, w; logic [31:0] p, di; logic [13:0] ad;
        run_xfer(1'b0, 14'h0300, 32'h0, 8, 32'hA5A55A5A, 0, rc, rn, nl, lh, e, p, w, ad, di);
        total++; if (rc !== 10) begin bad++; $display("FAIL tie_ready_cycle got %0d want 10", rc); end
        total++; if ({e, p} !== {1'b0, 32'hA5A55A5A}) begin bad++;
            $display("FAIL tie_resp got err=%b prdata=%h want 0/a5a55a5a", e, p); end
        total++; if (TimeoutCount !== 16'd2) begin bad++; $display("FAIL tie_count got %0d want 2", TimeoutCount); end
    endtask

    task automatic test_abort();
        int rc, rn, nl, lh; logic e, w; logic [31:0] p, di; logic [13:0] ad;
        run_xfer(1'b0, 14'h0111, 32'h0, -1, 32'h0, 3, rc, rn, nl, lh, e, p, w, ad, di);
        total++; if ({rn, nl, lh} !== {32'd0, 32'd3, 32'd1}) begin bad++;
            $display("FAIL abort_bus got readies=%0d ncs_low=%0d latch=%0d want 0/3/1", rn, nl, lh); end
        total++; if (TimeoutCount !== 16'd2) begin bad++; $display("FAIL abort_count got %0d want 2", TimeoutCount); end
        run_xfer(1'b1, 14'h0222, 32'h0BADF00D, 1, 32'h0, 0, rc, rn, nl, lh, e, p, w, ad, di);
        total++; if ({rc, e, p, din_ok(di)} !== {32'd3, 1'b0, 32'h0, 1'b1}) begin bad++;
            $display("FAIL abort_next got ready_cycle=%0d err=%b prdata=%h din=%h want 3/0/0/0badf00d", rc, e, p, di); end
    endtask

    function automatic logic din_ok(input logic [31:0] v);
        din_ok = (v == 32'h0BADF00D);
    endfunction

    task automatic test_back_to_back();
        // Read acked in its issue cycle, then a write set up right after RESP.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 14'h0010; RamBusDataOut = 32'h0F0F0F0F;
        tick();                                   // T1: issue
        PENABLE = 1'b1; RamBusAck = 1'b1;
        tick();                                   // T2: resp
        RamBusAck = 1'b0;
        total++; if ({PREADY, PRDATA, RamBusnCs} !== {1'b1, 32'h0F0F0F0F, 1'b1}) begin bad++;
            $display("FAIL b2b_first got pready=%b prdata=%h ncs=%b want 1/0f0f0f0f/1", PREADY, PRDATA, RamBusnCs); end
        PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 14'h3FFF; PWDATA = 32'h89ABCDEF;
        tick();                                   // T3: idle, new setup phase
        total++; if ({RamBusnCs, PREADY} !== 2'b10) begin bad++;
            $display("FAIL b2b_gap got ncs=%b pready=%b want 1/0", RamBusnCs, PREADY); end
        tick();                                   // T4: second issue
        PENABLE = 1'b1; RamBusAck = 1'b1;
        total++; if ({RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress} !== {3'b011, 14'h3FFF}) begin bad++;
            $display("FAIL b2b_issue got ncs/latch/wr=%b%b%b addr=%h want 011/3fff", RamBusnCs, RamBusLatch, RamBusWrnRd, RamBusAddress); end
        tick();                                   // T5: second resp
        RamBusAck = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        total++; if ({PREADY, PSLVERR, PRDATA} !== {2'b10, 32'h0}) begin bad++;
            $display("FAIL b2b_second got pready=%b err=%b prdata=%h want 1/0/0", PREADY, PSLVERR, PRDATA); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 14'h0155;
        tick(); PENABLE = 1'b1;                   // T1
        tick(); tick();                           // T3: waiting
        total++; if (RamBusnCs !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got ncs=%b want 0", RamBusnCs); end
        nRst = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        total++; if ({RamBusnCs, RamBusLatch, RamBusWrnRd, PREADY, PSLVERR} !== 5'b10000) begin bad++;
            $display("FAIL rst_mid_ctl got ncs/latch/wr/rdy/err=%b%b%b%b%b want 10000", RamBusnCs, RamBusLatch, RamBusWrnRd, PREADY, PSLVERR); end
        total++; if ({RamBusAddress, RamBusDataIn, PRDATA, TimeoutCount} !== 94'h0) begin bad++;
            $display("FAIL rst_mid_data got addr=%h din=%h prdata=%h tc=%0d want 0", RamBusAddress, RamBusDataIn, PRDATA, TimeoutCount); end
        nRst = 1'b1; RamBusAck = 1'b1; RamBusDataOut = 32'h11112222;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({PREADY, RamBusnCs, PRDATA} !== {2'b01, 32'h0}) begin bad++;
                $display("FAIL late_ack got pready=%b ncs=%b prdata=%h want 0/1/0", PREADY, RamBusnCs, PRDATA); end
        end
        RamBusAck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_issue_ack();
        test_timeout(16'd1);
        test_timeout(16'd2);
        test_ack_timeout_tie();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
